// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - measurement bus between signal source and period meter
// Purpose: bundles the measured input, the enable and the measurement results.
// Ports (signals):
//   sig_in    - measured square wave, asynchronous to the meter clock
//   enable    - measurement enable; low = idle and cleared
//   period    - last rise-to-rise period in meter clock cycles
//   high_time - high-phase length within that period
//   valid     - one-cycle pulse when period/high_time update
//   locked    - latest period equals the previous one
//   timeout   - sticky: no rising edge for TIMEOUT cycles
// Modports: master drives sig_in/enable, slave (the meter) drives the results.
interface clk_period_meter_if #(
  parameter int WIDTH = 32
);
  logic             sig_in;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_in, enable,
    input  period, high_time, valid, locked, timeout
  );

  modport slave (
    input  sig_in, enable,
    output period, high_time, valid, locked, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a divided square wave
// Purpose: recovers the divisor of a clock divider output by counting clk_in cycles
//   between synchronised rising edges, with lock detection and a sticky timeout.
// Ports:
//   clk_in  - system clock, all logic on posedge
//   reset_n - asynchronous active-low reset
//   bus     - clk_period_meter_if.slave (sig_in, enable in; results out)
module clk_period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**24
) (
  input  logic               clk_in,
  input  logic               reset_n,
  clk_period_meter_if.slave  bus
);
  localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sig_d;
  logic [WIDTH-1:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]       r_hi, w_hi_nxt;
  logic [WIDTH-1:0]       r_period, w_period_nxt;
  logic [WIDTH-1:0]       r_high, w_high_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_locked, w_locked_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic                   w_sig_s, w_rise, w_fall;

  assign w_sig_s = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_sig_s & ~r_sig_d;
  assign w_fall  = ~w_sig_s & r_sig_d;

  // Synchroniser chain plus one extra flop for edge detection.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
      r_sig_d <= w_sig_s;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;
    if (!bus.enable) begin
      // Disabling wipes every result so a re-enable starts from a clean slate.
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_hi_nxt      = '0;
      w_period_nxt  = '0;
      w_high_nxt    = '0;
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
          w_cnt_nxt   = '0;
        end
        S_ARM: begin
          // The partial period before the first rise is discarded.
          if (w_rise) begin
            w_state_nxt = S_MEASURE;
            w_cnt_nxt   = ONE;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_period_nxt  = r_cnt;
            w_high_nxt    = r_hi;
            w_valid_nxt   = 1'b1;
            w_cnt_nxt     = ONE;
            w_locked_nxt  = (r_cnt == r_period) && (r_period != '0);
            w_timeout_nxt = 1'b0;
          end else if (r_cnt == TO_VAL) begin
            w_state_nxt   = S_ARM;
            w_cnt_nxt     = '0;
            w_period_nxt  = '0;
            w_high_nxt    = '0;
            w_locked_nxt  = 1'b0;
            w_timeout_nxt = 1'b1;
          end else begin
            if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + ONE;
            if (w_fall) w_hi_nxt = r_cnt;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high;
  assign bus.valid     = r_valid;
  assign bus.locked    = r_locked;
  assign bus.timeout   = r_timeout;
endmodule
